// File: rtl/xdma_dsc_byp_pkg.sv
// Shared types for the XDMA descriptor-bypass arbiter.
// The struct fields are sized at the block's default widths. Narrower ports are zero-extended into them.
package xdma_dsc_byp_pkg;

  localparam int OUT_W      = 8;
  localparam int DSC_ADDR_W = 64;
  localparam int DSC_LEN_W  = 28;
  localparam int DSC_CTL_W  = 16;

  typedef struct packed {
    logic [DSC_ADDR_W-1:0] src;
    logic [DSC_ADDR_W-1:0] dst;
    logic [DSC_LEN_W-1:0]  len;
    logic [DSC_CTL_W-1:0]  ctl;
  } dsc_byp_t;

  typedef enum logic {ST_GRANT, ST_ISSUE} state_t;

endpackage

// File: rtl/xdma_dsc_byp_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
// The search starts one above the previous winner and wraps modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

  // NOTE: every output of a combinational block is given a default first, so no path can infer a latch.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(last) + i) % N]) begin
        found                        = 1'b1;
        gnt[(int'(last) + i) % N]    = 1'b1;
        gnt_idx                      = IDX_W'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/xdma_dsc_byp_arbiter.sv
// Round-robin scheduler feeding one XDMA descriptor-bypass channel.
// It stages one descriptor, issues it, and caps in-flight descriptors with a credit count.
module xdma_dsc_byp_arbiter
  import xdma_dsc_byp_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int LEN_W   = 28,
  parameter int CTL_W   = 16,
  parameter int MAX_OUT = 8
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_src,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_dst,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ*CTL_W-1:0]   req_ctl,
  input  logic                       dsc_byp_ready,
  output logic                       dsc_byp_load,
  output logic [ADDR_W-1:0]          dsc_byp_src_addr,
  output logic [ADDR_W-1:0]          dsc_byp_dst_addr,
  output logic [LEN_W-1:0]           dsc_byp_len,
  output logic [CTL_W-1:0]           dsc_byp_ctl,
  input  logic                       dsc_done,
  output logic [OUT_W-1:0]           outstanding,
  output logic [31:0]                issued_cnt,
  output logic                       err_zero_len,
  output logic                       err_underflow,
  input  logic                       clr_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  last_q, last_d;
  dsc_byp_t          stage_q, stage_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [31:0]       issued_q, issued_d;
  logic              err_zero_q, err_zero_d;
  logic              err_under_q, err_under_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  dsc_byp_t           sel;
  logic               can_grant;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel.src = DSC_ADDR_W'(req_src[int'(gnt_idx)*ADDR_W +: ADDR_W]);
    sel.dst = DSC_ADDR_W'(req_dst[int'(gnt_idx)*ADDR_W +: ADDR_W]);
    sel.len = DSC_LEN_W'(req_len[int'(gnt_idx)*LEN_W +: LEN_W]);
    sel.ctl = DSC_CTL_W'(req_ctl[int'(gnt_idx)*CTL_W +: CTL_W]);
  end

  // Credits come from the registered count, so a completion pulse frees a slot only from the next cycle.
  assign can_grant = (state_q == ST_GRANT) && (outstanding_q < OUT_W'(MAX_OUT)) && (|req_valid);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    stage_d       = stage_q;
    issued_d      = issued_q;
    outstanding_d = outstanding_q;
    err_zero_d    = err_zero_q & ~clr_err;
    err_under_d   = err_under_q & ~clr_err;
    req_ready     = '0;
    dsc_byp_load  = 1'b0;

    unique case (state_q)
      ST_GRANT: begin
        if (can_grant) begin
          req_ready = gnt;
          last_d    = gnt_idx;
          stage_d   = sel;
          if (sel.len == '0) err_zero_d = 1'b1;
          else               state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (dsc_byp_ready) begin
          dsc_byp_load = 1'b1;
          issued_d     = issued_q + 32'd1;
          state_d      = ST_GRANT;
        end
      end
      default: state_d = ST_GRANT;
    endcase

    unique case ({dsc_byp_load, dsc_done})
      2'b10: outstanding_d = outstanding_q + OUT_W'(1);
      2'b01: begin
        if (outstanding_q == '0) err_under_d   = 1'b1;
        else                     outstanding_d = outstanding_q - OUT_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q       <= ST_GRANT;
      last_q        <= IDX_W'(NUM_REQ - 1);
      // NOTE: the staging register is reset as well because its contents drive the output ports directly.
      stage_q       <= '0;
      outstanding_q <= '0;
      issued_q      <= '0;
      err_zero_q    <= 1'b0;
      err_under_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      stage_q       <= stage_d;
      outstanding_q <= outstanding_d;
      issued_q      <= issued_d;
      err_zero_q    <= err_zero_d;
      err_under_q   <= err_under_d;
    end
  end

  assign dsc_byp_src_addr = stage_q.src[ADDR_W-1:0];
  assign dsc_byp_dst_addr = stage_q.dst[ADDR_W-1:0];
  assign dsc_byp_len      = stage_q.len[LEN_W-1:0];
  assign dsc_byp_ctl      = stage_q.ctl[CTL_W-1:0];
  assign outstanding      = outstanding_q;
  assign issued_cnt       = issued_q;
  assign err_zero_len     = err_zero_q;
  assign err_underflow    = err_under_q;

endmodule

// File: tb/tb_xdma_dsc_byp_arbiter.sv
// Directed bench for xdma_dsc_byp_arbiter: NUM_REQ=4, MAX_OUT=2.
// Inputs are driven on the falling edge and outputs are sampled 1 ns later.
module tb_xdma_dsc_byp_arbiter;

  localparam int NR = 4, AW = 64, LW = 28, CW = 16, MO = 2;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_src, req_dst;
  logic [NR*LW-1:0]  req_len;
  logic [NR*CW-1:0]  req_ctl;
  logic              dsc_byp_ready, dsc_byp_load, dsc_done, clr_err;
  logic [AW-1:0]     dsc_byp_src_addr, dsc_byp_dst_addr;
  logic [LW-1:0]     dsc_byp_len;
  logic [CW-1:0]     dsc_byp_ctl;
  logic [7:0]        outstanding;
  logic [31:0]       issued_cnt;
  logic              err_zero_len, err_underflow;

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  xdma_dsc_byp_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .CTL_W(CW), .MAX_OUT(MO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_len(req_len), .req_ctl(req_ctl),
    .dsc_byp_ready(dsc_byp_ready), .dsc_byp_load(dsc_byp_load),
    .dsc_byp_src_addr(dsc_byp_src_addr), .dsc_byp_dst_addr(dsc_byp_dst_addr),
    .dsc_byp_len(dsc_byp_len), .dsc_byp_ctl(dsc_byp_ctl),
    .dsc_done(dsc_done), .outstanding(outstanding), .issued_cnt(issued_cnt),
    .err_zero_len(err_zero_len), .err_underflow(err_underflow), .clr_err(clr_err)
  );

  // Advance to the next falling edge. Inputs are driven there, and the caller samples after #1.
  task automatic next_cycle();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [LW-1:0] l, input logic [CW-1:0] c);
    req_src[i*AW +: AW] = s;
    req_dst[i*AW +: AW] = d;
    req_len[i*LW +: LW] = l;
    req_ctl[i*CW +: CW] = c;
  endtask

  task automatic reset_dut();
    @(negedge ACLK);
    ARESET = 1'b1; req_valid = '0; dsc_byp_ready = 1'b0; dsc_done = 1'b0; clr_err = 1'b0;
    next_cycle();
    next_cycle();
    ARESET = 1'b0;
    for (int i = 0; i < NR; i++)
      set_req(i, AW'(64'h100 * (i + 1)), AW'(64'h8000 + 64'h100 * i), LW'(16 * (i + 1)), CW'(i + 1));
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if (outstanding !== 8'd0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (issued_cnt !== 32'd0) begin errors++; $display("FAIL reset_issued got=%0d exp=0", issued_cnt); end
    checks++; if ({err_zero_len, err_underflow} !== 2'b00) begin errors++; $display("FAIL reset_errs got=%b exp=00", {err_zero_len, err_underflow}); end
    checks++; if ({dsc_byp_src_addr, dsc_byp_dst_addr, dsc_byp_len, dsc_byp_ctl} !== '0) begin errors++; $display("FAIL reset_desc got src=%h len=%h exp=0", dsc_byp_src_addr, dsc_byp_len); end
    checks++; if ({req_ready, dsc_byp_load} !== 5'b0) begin errors++; $display("FAIL reset_ready_load got=%b exp=00000", {req_ready, dsc_byp_load}); end
  endtask

  task automatic test_round_robin();
    reset_dut();
    req_valid = 4'b1111; dsc_byp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dsc_done = 1'b0;
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant_%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
      checks++; if (dsc_byp_load !== 1'b0) begin errors++; $display("FAIL rr_noload_%0d got=%b exp=0", k, dsc_byp_load); end
      next_cycle();
      dsc_done = (k > 0);
      #1;
      checks++; if (dsc_byp_load !== 1'b1) begin errors++; $display("FAIL rr_load_%0d got=%b exp=1", k, dsc_byp_load); end
      checks++; if (dsc_byp_src_addr !== AW'(64'h100 * ((k % 4) + 1))) begin errors++; $display("FAIL rr_src_%0d got=%h exp=%h", k, dsc_byp_src_addr, 64'h100 * ((k % 4) + 1)); end
      next_cycle();
    end
    req_valid = '0; dsc_done = 1'b0;
    next_cycle();
    dsc_done = 1'b1;
    next_cycle();
    dsc_done = 1'b0;
    #1;
    checks++; if (issued_cnt !== 32'd5) begin errors++; $display("FAIL rr_issued got=%0d exp=5", issued_cnt); end
    checks++; if (outstanding !== 8'd0) begin errors++; $display("FAIL rr_outstanding got=%0d exp=0", outstanding); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    set_req(2, 64'h1000, 64'h2000, 28'h40, 16'h00a5);
    req_valid = 4'b0100; dsc_byp_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      #1;
      checks++;
      if ({dsc_byp_load, req_ready} !== 5'b0 || dsc_byp_src_addr !== 64'h1000 ||
          dsc_byp_dst_addr !== 64'h2000 || dsc_byp_len !== 28'h40 || dsc_byp_ctl !== 16'h00a5) begin
        errors++;
        $display("FAIL bp_hold_%0d got load=%b rdy=%b src=%h dst=%h len=%h exp load=0 rdy=0000 src=1000 dst=2000 len=40",
                 c, dsc_byp_load, req_ready, dsc_byp_src_addr, dsc_byp_dst_addr, dsc_byp_len);
      end
    end
    next_cycle();
    req_valid = '0; dsc_byp_ready = 1'b1;
    #1;
    checks++; if (dsc_byp_load !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", dsc_byp_load); end
    next_cycle();
    #1;
    checks++; if (dsc_byp_load !== 1'b0) begin errors++; $display("FAIL bp_single got=%b exp=0", dsc_byp_load); end
    checks++; if (outstanding !== 8'd1) begin errors++; $display("FAIL bp_outstanding got=%0d exp=1", outstanding); end
  endtask

  task automatic test_credit_ceiling();
    reset_dut();
    req_valid = 4'b0001; dsc_byp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL cc_grant_%0d got=%b exp=0001", k, req_ready); end
      next_cycle();
      #1;
      checks++; if (dsc_byp_load !== 1'b1) begin errors++; $display("FAIL cc_load_%0d got=%b exp=1", k, dsc_byp_load); end
      next_cycle();
    end
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL cc_full got=%b exp=0000", req_ready); end
    checks++; if (outstanding !== 8'd2) begin errors++; $display("FAIL cc_out2 got=%0d exp=2", outstanding); end
    next_cycle();
    dsc_done = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL cc_done_cycle got=%b exp=0000", req_ready); end
    next_cycle();
    dsc_done = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL cc_resume got=%b exp=0001", req_ready); end
    checks++; if (outstanding !== 8'd1) begin errors++; $display("FAIL cc_out1 got=%0d exp=1", outstanding); end
    next_cycle();
    dsc_done = 1'b1;
    #1;
    checks++; if (dsc_byp_load !== 1'b1) begin errors++; $display("FAIL cc_load3 got=%b exp=1", dsc_byp_load); end
    next_cycle();
    dsc_done = 1'b0; req_valid = '0;
    #1;
    checks++; if (outstanding !== 8'd1) begin errors++; $display("FAIL cc_same_cycle got=%0d exp=1", outstanding); end
    checks++; if (issued_cnt !== 32'd3) begin errors++; $display("FAIL cc_issued got=%0d exp=3", issued_cnt); end
  endtask

  task automatic test_zero_len();
    reset_dut();
    set_req(1, 64'h1111, 64'h2222, 28'h0, 16'h1);
    req_valid = 4'b0110; dsc_byp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL zl_grant1 got=%b exp=0010", req_ready); end
    next_cycle();
    #1;
    checks++; if (dsc_byp_load !== 1'b0) begin errors++; $display("FAIL zl_noload got=%b exp=0", dsc_byp_load); end
    checks++; if (err_zero_len !== 1'b1) begin errors++; $display("FAIL zl_flag got=%b exp=1", err_zero_len); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL zl_next got=%b exp=0100", req_ready); end
    checks++; if (outstanding !== 8'd0) begin errors++; $display("FAIL zl_credit got=%0d exp=0", outstanding); end
    next_cycle();
    req_valid = '0;
    #1;
    checks++; if (dsc_byp_load !== 1'b1 || dsc_byp_len !== 28'd48) begin errors++; $display("FAIL zl_load2 got load=%b len=%h exp load=1 len=30", dsc_byp_load, dsc_byp_len); end
    next_cycle();
    clr_err = 1'b1;
    next_cycle();
    clr_err = 1'b0;
    #1;
    checks++; if (err_zero_len !== 1'b0) begin errors++; $display("FAIL zl_clear got=%b exp=0", err_zero_len); end
  endtask

  task automatic test_underflow();
    reset_dut();
    dsc_done = 1'b1;
    next_cycle();
    dsc_done = 1'b0;
    #1;
    checks++; if (outstanding !== 8'd0) begin errors++; $display("FAIL uf_out got=%0d exp=0", outstanding); end
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got=%b exp=1", err_underflow); end
    dsc_done = 1'b1; clr_err = 1'b1;
    next_cycle();
    dsc_done = 1'b0;
    #1;
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins got=%b exp=1", err_underflow); end
    next_cycle();
    clr_err = 1'b0;
    #1;
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got=%b exp=0", err_underflow); end
  endtask

  task automatic test_reset_mid_issue();
    reset_dut();
    dsc_done = 1'b1;
    next_cycle();
    dsc_done = 1'b0;
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant2 got=%b exp=0100", req_ready); end
    next_cycle();
    req_valid = '0; ARESET = 1'b1;
    #1;
    checks++; if (dsc_byp_load !== 1'b0) begin errors++; $display("FAIL rm_hold got=%b exp=0", dsc_byp_load); end
    next_cycle();
    ARESET = 1'b0; dsc_byp_ready = 1'b1;
    #1;
    checks++; if (dsc_byp_load !== 1'b0) begin errors++; $display("FAIL rm_noload got=%b exp=0", dsc_byp_load); end
    checks++;
    if ({dsc_byp_src_addr, dsc_byp_len} !== '0 || outstanding !== 8'd0 || issued_cnt !== 32'd0 ||
        err_underflow !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rm_state got src=%h len=%h out=%0d iss=%0d uf=%b rdy=%b exp all 0",
               dsc_byp_src_addr, dsc_byp_len, outstanding, issued_cnt, err_underflow, req_ready);
    end
    next_cycle();
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first got=%b exp=0001", req_ready); end
    next_cycle();
    req_valid = '0;
    #1;
    checks++; if (dsc_byp_load !== 1'b1 || dsc_byp_src_addr !== 64'h100) begin errors++; $display("FAIL rm_load got load=%b src=%h exp load=1 src=100", dsc_byp_load, dsc_byp_src_addr); end
  endtask

  initial begin
    ARESET = 1'b1; req_valid = '0; dsc_byp_ready = 1'b0; dsc_done = 1'b0; clr_err = 1'b0;
    req_src = '0; req_dst = '0; req_len = '0; req_ctl = '0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_credit_ceiling();
    test_zero_len();
    test_underflow();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xdma_dsc_byp_arbiter.md
# xdma_dsc_byp_arbiter

Round-robin scheduler that shares one XDMA descriptor-bypass channel among `NUM_REQ` descriptor producers. Each producer presents complete descriptors on a valid/ready port. The block picks one, holds it in a single staging register and loads it into XDMA using the `dsc_byp_ready`/`dsc_byp_load` handshake. It limits in-flight descriptors with a credit counter that completion pulses replenish. It sits between the register-programmed descriptor sources behind the bypass controller's AXI4-Lite slave and the XDMA IP bypass port.

## Interface
- `NUM_REQ`, default 4: number of requester ports, range 2..8.
- `ADDR_W`, default 64: source and destination address width.
- `LEN_W`, default 28: byte-length width.
- `CTL_W`, default 16: descriptor control-field width.
- `MAX_OUT`, default 8: maximum number of descriptors loaded but not yet completed, range 1..255.

Ports (name, direction, width, meaning):
- `ACLK` in 1: the only clock.
- `ARESET` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a descriptor.
- `req_ready` out NUM_REQ: one-hot accept. At most one bit is high per cycle.
- `req_src` in NUM_REQ*ADDR_W: packed source addresses.
- `req_dst` in NUM_REQ*ADDR_W: packed destination addresses.
- `req_len` in NUM_REQ*LEN_W: packed byte lengths.
- `req_ctl` in NUM_REQ*CTL_W: packed control fields.
- `dsc_byp_ready` in 1: XDMA can accept a descriptor.
- `dsc_byp_load` out 1: descriptor load strobe.
- `dsc_byp_src_addr` out ADDR_W, `dsc_byp_dst_addr` out ADDR_W, `dsc_byp_len` out LEN_W, `dsc_byp_ctl` out CTL_W: the staged descriptor.
- `dsc_done` in 1: one-cycle completion pulse from XDMA status.
- `outstanding` out 8: descriptors currently in flight.
- `issued_cnt` out 32: total descriptors loaded, wraps.
- `err_zero_len` out 1: sticky; set when a zero-length descriptor was dropped.
- `err_underflow` out 1: sticky; set when `dsc_done` arrived with `outstanding`==0.
- `clr_err` in 1: clears both sticky error flags.

## Operation
The FSM has two states, GRANT and ISSUE.
- **GRANT**
  - A grant happens only when `outstanding` < MAX_OUT and at least one `req_valid` bit is set.
  - The winner is the first set `req_valid` bit searching upward from `last+1`, wrapping modulo NUM_REQ.
  - On a grant, `req_ready[winner]` is high for exactly that cycle.
  - The descriptor is captured into the staging register and `last` is set to the winner.
  - If the captured `req_len`==0, the descriptor is dropped: `err_zero_len` is set and the FSM stays in GRANT. No credit is used and nothing is loaded.
  - Otherwise the FSM moves to ISSUE.
- **ISSUE**
  - `dsc_byp_load` = (state==ISSUE) & `dsc_byp_ready`, combinational from the registered state.
  - In the load cycle, `outstanding` increments, `issued_cnt` increments and the FSM returns to GRANT.
  - While `dsc_byp_ready`=0, the descriptor outputs are held stable and `req_ready` is all zero.
- **Credits**
  - `dsc_done` decrements `outstanding`.
  - A load and a `dsc_done` in the same cycle leave `outstanding` unchanged.
  - `dsc_done` with `outstanding`==0 leaves it at 0 and sets `err_underflow`.
- **Errors**: `clr_err` clears the sticky flags. A set event in the same cycle as `clr_err` wins.
- **Grant fairness**: requester i waits for at most NUM_REQ−1 other grants while it holds `req_valid`.

## Timing
- **Reset**: the following take these values in the cycle after `ARESET`=1.
  - FSM state = GRANT, `last` = NUM_REQ−1, so requester 0 has first priority.
  - `outstanding`=0, `issued_cnt`=0, both error flags = 0.
  - Descriptor outputs = 0, `req_ready`=0, `dsc_byp_load`=0.
- **Reset mid-ISSUE**: the staged descriptor is discarded and not loaded. The requester has already seen its ready.
- **Latency**: a descriptor granted in cycle N loads in cycle N+1 at the earliest. Steady-state throughput is one descriptor per 2 cycles.
- **Combinational paths**: `req_ready` is derived from registered state, `outstanding` and `req_valid`. It does not depend on `dsc_byp_ready`.
- **Back-pressure**: in a cycle with `outstanding`==MAX_OUT and a `dsc_done` pulse, no grant is made. Grants resume in the next cycle.

## Structure
- Package `xdma_dsc_byp_pkg` holds:
  - the `dsc_byp_t` struct (src, dst, len, ctl);
  - the FSM state enum `{ST_GRANT, ST_ISSUE}`;
  - the `OUT_W`=8 constant.
- Sub-module `rr_arbiter`: combinational round-robin priority pick. Inputs are the request vector and `last`; outputs are a one-hot grant and its index. The top-level block holds the FSM, staging register and counters.

## Test plan
- **Round-robin order**: NUM_REQ=4, all `req_valid`=1 and `dsc_byp_ready`=1 permanently, `dsc_done` fired two cycles after each load -> grant order 0,1,2,3,0. A load follows every grant by one cycle, and `issued_cnt`=5 after five loads.
- **Back-pressure hold**: requester 2 only with src=0x1000, dst=0x2000, len=0x40. Hold `dsc_byp_ready`=0 for 10 cycles -> outputs stay stable and `req_ready`=0. Release -> a single load and `outstanding`=1.
- **Credit ceiling**: MAX_OUT=2, no `dsc_done` -> exactly 2 loads, then no `req_ready`. Pulse `dsc_done` -> one more grant and load. Pulse `dsc_done` in the same cycle as a load -> `outstanding` unchanged.
- **Zero-length drop**: requester 1 presents len=0 -> `req_ready[1]` pulses, there is no load and `err_zero_len`=1. The next grant goes to requester 2. `clr_err` -> flag returns to 0.
- **Underflow**: `dsc_done` with `outstanding`=0 -> `outstanding` stays 0 and `err_underflow`=1.
- **Reset mid-operation**: assert `ARESET` during ISSUE -> no load. All outputs match the reset values listed under Timing, and the first grant after reset goes to requester 0.
